// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM user-side port arbiter:
//   - data/address/burst-length widths used by the controller request ports
//   - FSM state encoding for the burst arbiter
// -----------------------------------------------------------------------------
package sdram_pkg;

  localparam int SDRAM_DW = 16;
  localparam int SDRAM_AW = 24;
  localparam int BURST_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4
  } state_e;

endpackage

// File: rtl/sdram_sync_fifo.sv
// -----------------------------------------------------------------------------
// sdram_sync_fifo
// Single-clock first-word-fall-through FIFO with an occupancy level output.
// Ports:
//   clk, rst      clock and synchronous active-high reset (empties the FIFO)
//   push_i/data_i write side; a push while full is dropped unless a pop
//                 happens in the same cycle
//   pop_i/data_o  read side; data_o shows the head word, 0 when empty;
//                 a pop while empty is ignored
//   level_o       number of stored words (0..DEPTH)
// -----------------------------------------------------------------------------
module sdram_sync_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             empty_s, full_s, do_push_s, do_pop_s;

  assign empty_s   = (level_q == '0);
  assign full_s    = (level_q == LW'(DEPTH));
  assign do_pop_s  = pop_i & ~empty_s;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign do_push_s = push_i & (~full_s | do_pop_s);

  assign data_o  = empty_s ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Read/write pointers and occupancy level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
// User-side front end of the SDRAM controller. A write FIFO collects the user
// write stream and is drained in fixed-length bursts on the controller write
// port; a read FIFO is prefetched in fixed-length bursts from the controller
// read port and drained by the user. Each direction walks its own circular
// address window. Write/read bursts are arbitrated round-robin when both are
// ready.
// Ports:
//   clk, rst                    SDRAM clock, synchronous active-high reset
//   sdram_init_done             gates all burst requests
//   wr_min/max_addr             write address window (inclusive)
//   rd_min/max_addr             read address window (inclusive)
//   rd_enable                   allows new read prefetch bursts
//   wr_valid/wr_ready/wr_data   user write stream
//   rd_valid/rd_ready/rd_data   user read stream (FWFT)
//   sdram_wr_*, sdram_din       controller write request port
//   sdram_rd_*, sdram_dout      controller read request port
// -----------------------------------------------------------------------------
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int BURST_LEN  = 256,
  parameter int FIFO_DEPTH = 512,
  parameter int AW         = SDRAM_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sdram_init_done,
  input  logic [AW-1:0]       wr_min_addr,
  input  logic [AW-1:0]       wr_max_addr,
  input  logic [AW-1:0]       rd_min_addr,
  input  logic [AW-1:0]       rd_max_addr,
  input  logic                rd_enable,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [SDRAM_DW-1:0] wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [SDRAM_DW-1:0] rd_data,
  output logic                sdram_wr_req,
  input  logic                sdram_wr_ack,
  output logic [AW-1:0]       sdram_wr_addr,
  output logic [BURST_W-1:0]  sdram_wr_burst,
  output logic [SDRAM_DW-1:0] sdram_din,
  output logic                sdram_rd_req,
  input  logic                sdram_rd_ack,
  output logic [AW-1:0]       sdram_rd_addr,
  output logic [BURST_W-1:0]  sdram_rd_burst,
  input  logic [SDRAM_DW-1:0] sdram_dout
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BURST_W-1:0] LAST_CNT = BURST_W'(BURST_LEN - 1);

  state_e             state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]      inflight_q, inflight_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               last_rd_q, last_rd_d;   // 1: read was granted last
  logic               wr_req_q, rd_req_q;

  logic [LW-1:0]      wr_level_s, rd_level_s, rd_free_s;
  logic               want_wr_s, want_rd_s;
  logic               wr_push_s, wr_pop_s, rd_push_s, rd_pop_s;

  // Start of the next burst in a window; restart at min when the following
  // burst would run past max, so no burst straddles the window end.
  function automatic logic [AW-1:0] next_burst_addr(input logic [AW-1:0] ptr,
                                                    input logic [AW-1:0] min_a,
                                                    input logic [AW-1:0] max_a);
    logic [AW-1:0] nxt;
    nxt = ptr + AW'(BURST_LEN);
    if ((nxt + AW'(BURST_LEN - 1)) > max_a) begin
      return min_a;
    end else begin
      return nxt;
    end
  endfunction

  assign wr_ready  = (wr_level_s != LW'(FIFO_DEPTH));
  assign rd_valid  = (rd_level_s != '0);
  assign wr_push_s = wr_valid & wr_ready;
  assign rd_pop_s  = rd_valid & rd_ready;

  // Free read-FIFO space discounts words already granted but not yet returned.
  assign rd_free_s = LW'(FIFO_DEPTH) - rd_level_s - inflight_q;
  assign want_wr_s = (wr_level_s >= LW'(BURST_LEN));
  assign want_rd_s = rd_enable & (rd_free_s >= LW'(BURST_LEN));

  assign sdram_wr_req   = wr_req_q;
  assign sdram_rd_req   = rd_req_q;
  assign sdram_wr_addr  = wr_ptr_q;
  assign sdram_rd_addr  = rd_ptr_q;
  assign sdram_wr_burst = BURST_W'(BURST_LEN);
  assign sdram_rd_burst = BURST_W'(BURST_LEN);

  sdram_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SDRAM_DW)) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_push_s),
    .data_i  (wr_data),
    .pop_i   (wr_pop_s),
    .data_o  (sdram_din),
    .level_o (wr_level_s)
  );

  sdram_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SDRAM_DW)) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_push_s),
    .data_i  (sdram_dout),
    .pop_i   (rd_pop_s),
    .data_o  (rd_data),
    .level_o (rd_level_s)
  );

  // Arbitration and burst sequencing: next state, counters and FIFO strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_rd_d  = last_rd_q;
    wr_pop_s   = 1'b0;
    rd_push_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Write wins a tie only when read was served last.
        if (sdram_init_done && want_wr_s && (!want_rd_s || last_rd_q)) begin
          state_d   = ST_WR_REQ;
          cnt_d     = '0;
          last_rd_d = 1'b0;
        end else if (sdram_init_done && want_rd_s) begin
          state_d    = ST_RD_REQ;
          cnt_d      = '0;
          last_rd_d  = 1'b1;
          inflight_d = inflight_q + LW'(BURST_LEN);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ, ST_WR_DATA: begin
        if (sdram_wr_ack) begin
          wr_pop_s = 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            wr_ptr_d = next_burst_addr(wr_ptr_q, wr_min_addr, wr_max_addr);
          end else begin
            state_d = ST_WR_DATA;
            cnt_d   = cnt_q + BURST_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RD_REQ, ST_RD_DATA: begin
        if (sdram_rd_ack) begin
          rd_push_s  = 1'b1;
          inflight_d = inflight_q - LW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            rd_ptr_d = next_burst_addr(rd_ptr_q, rd_min_addr, rd_max_addr);
          end else begin
            state_d = ST_RD_DATA;
            cnt_d   = cnt_q + BURST_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, window pointers and registered request lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= wr_min_addr;
      rd_ptr_q   <= rd_min_addr;
      last_rd_q  <= 1'b1;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_rd_q  <= last_rd_d;
      wr_req_q   <= (state_d == ST_WR_REQ);
      rd_req_q   <= (state_d == ST_RD_REQ);
    end
  end

endmodule
